// File: rtl/stream_mux_rr.sv
// Packet-atomic N-to-1 stream mux with fixed-select or round-robin arbitration.
// One IDLE arbitration cycle per packet, one-cycle output latency; in_ready follows the output register.
module stream_mux_rr #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    gnt_q, gnt_d;
  logic [SEL_W-1:0]    last_gnt_q, last_gnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;

  logic                accept;
  logic                fix_ok;
  logic                rr_found;
  logic [SEL_W-1:0]    rr_pick;
  logic [SEL_W-1:0]    rr_cand;

  // Round-robin search starts one past the previous winner and wraps.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_cand  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      rr_cand = SEL_W'((int'(last_gnt_q) + i) % N_CH);
      if (!rr_found && in_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  assign fix_ok = (int'(sel) < N_CH) && in_valid[sel];

  always_comb begin
    in_ready = '0;
    if (!rst && state_q == LOCKED && (!out_valid_q || out_ready)) begin
      in_ready[gnt_q] = 1'b1;
    end
  end

  assign accept = in_valid[gnt_q] && in_ready[gnt_q];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;

    // A consume and a fresh accept in the same cycle simply overwrite the register.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gnt_q)*DATA_W +: DATA_W];
      out_last_d  = in_last[gnt_q];
      out_ch_d    = gnt_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!mode && fix_ok) begin
          gnt_d      = sel;
          last_gnt_d = sel;
          state_d    = LOCKED;
        end else if (mode && rr_found) begin
          gnt_d      = rr_pick;
          last_gnt_d = rr_pick;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && in_last[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      last_gnt_q  <= SEL_W'(N_CH - 1);
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of input channels (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the data width per channel (1..64).
REQ-003 The block SHALL have parameter SEL_W, default 2, giving the channel index width (SEL_W = clog2(N_CH)).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-007 The block SHALL have port sel, input, SEL_W bits: the channel to grant in fixed mode.
REQ-008 The block SHALL have port in_data, input, N_CH*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 The block SHALL have port in_valid, input, N_CH bits: per-channel beat valid.
REQ-010 The block SHALL have port in_last, input, N_CH bits: per-channel end-of-packet marker.
REQ-011 The block SHALL have port in_ready, output, N_CH bits: per-channel beat accept.
REQ-012 The block SHALL have ports out_data (output, DATA_W), out_valid (output, 1), out_last (output, 1) and out_ch (output, SEL_W): registered output beat and its source channel.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-014 A transfer SHALL occur on a channel or output port only in a cycle where its valid and ready are both high.
REQ-015 The FSM SHALL have exactly two states: IDLE (no grant) and LOCKED (grant held in register gnt).
REQ-016 In IDLE with mode=0, if sel < N_CH and in_valid[sel]=1, then gnt SHALL load sel and the FSM SHALL go to LOCKED next cycle; otherwise it stays in IDLE.
REQ-017 In IDLE with mode=1, gnt SHALL load the first channel with in_valid=1, searching upward from (last_gnt+1) mod N_CH and wrapping; the FSM SHALL go to LOCKED; with no valid channel it stays in IDLE.
REQ-018 last_gnt SHALL update to the granted channel on every IDLE->LOCKED transition.
REQ-019 The mode and sel inputs SHALL be sampled only in IDLE; changes while LOCKED SHALL be ignored until the packet ends.
REQ-020 in_ready[k] SHALL be 1 only when state=LOCKED, k=gnt, and the output register is empty or out_ready=1; all other in_ready bits SHALL be 0, and in_ready SHALL be all 0 in IDLE.
REQ-021 An accepted beat SHALL appear on out_data/out_last, with out_ch=gnt and out_valid=1, on the next cycle (latency 1).
REQ-022 out_valid SHALL stay high, with out_data, out_last and out_ch held stable, until out_ready=1.
REQ-023 Simultaneous output consume and input accept SHALL replace the register contents with no bubble.
REQ-024 Output consume with no new accept SHALL clear out_valid.
REQ-025 Acceptance of a beat with in_last[gnt]=1 SHALL return the FSM to IDLE next cycle; each packet SHALL cost exactly one IDLE arbitration cycle.
REQ-026 A deasserted in_valid[gnt] while LOCKED SHALL hold the grant without timeout.
REQ-027 Non-granted channels SHALL never affect the output.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set state=IDLE, gnt=0, last_gnt=N_CH-1, out_valid=0, out_data=0, out_last=0 and out_ch=0.
REQ-029 During and immediately after reset, in_ready SHALL be all 0.
REQ-030 Reset asserted mid-packet SHALL discard the partial packet and any held output beat.
REQ-031 After reset, the first round-robin search SHALL start at channel 0.

Verification
REQ-032 Scenario: mode=1, all 4 channels valid with 1-beat packets (last=1), out_ready=1 -> out_ch sequence 0,1,2,3,0, one beat every 2 cycles.
REQ-033 Scenario: mode=0, sel=2, ch2 sends 3-beat packet 0xA1,0xA2,0xA3(last); sel switched to 1 after the first beat -> all 3 beats output with out_ch=2; ch1 is granted only after 0xA3.
REQ-034 Scenario: out_ready held 0 for 4 cycles while LOCKED with ch1 streaming -> out_data stable, in_ready[1]=0 during stall, no beat lost or duplicated after release.
REQ-035 Scenario: mode=0, sel=3 with in_valid[3]=0 and ch0 valid -> stays IDLE, in_ready all 0, out_valid=0.
REQ-036 Scenario: rst=1 pulsed on the second beat of a 4-beat packet -> next cycle out_valid=0 and state=IDLE; the first subsequent round-robin grant goes to the lowest valid channel.
REQ-037 Scenario: N_CH=8, DATA_W=16 build, random valid/last/out_ready for 10k cycles -> scoreboard confirms per-channel order, packet atomicity, and no starvation in mode=1.
